sum_mult_sched: RTL and testbench

SUM_MULT_SCHED -- requirements
Module: sum_mult_sched

---
 rtl/sum_mult_sched.sv | 127 ++++++++++++
 tb/tb_sum_mult_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_mult_sched.sv
// sum_mult_sched: two-requester round-robin issue scheduler for an
// external (A+B)*C pipeline, with per-requester credit limits and result routing.
module sum_mult_sched #(
    parameter int PIPE_LAT = 4,
    parameter int MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic [7:0]  c0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    input  logic [7:0]  c1,
    input  logic        hold,
    output logic        gnt0,
    output logic        gnt1,
    output logic [7:0]  pipe_a,
    output logic [7:0]  pipe_b,
    output logic [7:0]  pipe_c,
    output logic        pipe_ce,
    input  logic [16:0] pipe_y,
    output logic [16:0] res_y,
    output logic        res_valid0,
    output logic        res_valid1,
    output logic        busy,
    output logic [1:0]  state
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } state_t;

    state_t            cur, nxt;
    logic [PIPE_LAT:0] tag_v;
    logic [PIPE_LAT:0] tag_o;
    logic [CW-1:0]     cnt0, cnt1;
    logic              last;      // 1: requester 1 was granted most recently
    logic              elig0, elig1, any_gnt;

    assign pipe_ce    = !hold;
    assign res_y      = pipe_y;
    assign res_valid0 = tag_v[PIPE_LAT] & ~tag_o[PIPE_LAT] & pipe_ce;
    assign res_valid1 = tag_v[PIPE_LAT] &  tag_o[PIPE_LAT] & pipe_ce;
    assign busy       = |tag_v;
    assign state      = cur;

    // A credit returning in this cycle frees a slot for a same-cycle grant.
    assign elig0   = req0 & ~hold & ~rst & ((cnt0 < MAX_C) | res_valid0);
    assign elig1   = req1 & ~hold & ~rst & ((cnt1 < MAX_C) | res_valid1);
    assign gnt0    = elig0 & (~elig1 | last);
    assign gnt1    = elig1 & (~elig0 | ~last);
    assign any_gnt = gnt0 | gnt1;

    // Operand registers: load on grant, otherwise keep (bubble issued).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_a <= '0;
            pipe_b <= '0;
            pipe_c <= '0;
        end else if (gnt0) begin
            pipe_a <= a0;
            pipe_b <= b0;
            pipe_c <= c0;
        end else if (gnt1) begin
            pipe_a <= a1;
            pipe_b <= b1;
            pipe_c <= c1;
        end
    end

    // Tag pipeline tracking valid/owner alongside the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v <= '0;
            tag_o <= '0;
        end else if (pipe_ce) begin
            tag_v <= {tag_v[PIPE_LAT-1:0], any_gnt};
            tag_o <= {tag_o[PIPE_LAT-1:0], gnt1};
        end
    end

    // Outstanding-operation counters and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
            last <= 1'b1;
        end else begin
            if (gnt0 & ~res_valid0)      cnt0 <= cnt0 + ONE;
            else if (~gnt0 & res_valid0) cnt0 <= cnt0 - ONE;
            if (gnt1 & ~res_valid1)      cnt1 <= cnt1 + ONE;
            else if (~gnt1 & res_valid1) cnt1 <= cnt1 - ONE;
            if (any_gnt) last <= gnt1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= IDLE;
        else     cur <= nxt;
    end

    // FSM next-state logic; a stall overrides everything.
    always_comb begin
        nxt = cur;
        if (hold) begin
            nxt = STALL;
        end else begin
            unique case (cur)
                IDLE:    if (req0 | req1) nxt = ACTIVE;
                ACTIVE:  if (!busy && !(req0 | req1) && !any_gnt) nxt = IDLE;
                STALL:   nxt = (busy || req0 || req1) ? ACTIVE : IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_mult_sched.sv
// tb_sum_mult_sched: directed and random checks of the scheduler against a
// queue-based model of in-flight operations.
module tb_sum_mult_sched;

    localparam int LAT  = 4;
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst, req0, req1, hold;
    logic [7:0]  a0, b0, c0, a1, b1, c1;
    logic        gnt0, gnt1, pipe_ce, res_valid0, res_valid1, busy;
    logic [7:0]  pipe_a, pipe_b, pipe_c;
    logic [16:0] pipe_y, res_y;
    logic [1:0]  state;
    logic [16:0] dp [LAT];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit owner;
        int val;
        int rem;
    } op_t;

    op_t q[$];
    int  m_cnt[2];
    bit  m_last;
    int  m_state;
    bit  m_g0, m_g1;
    int  obs_g0, obs_g1, obs_rv0, obs_rv1, obs_y, obs_state;

    sum_mult_sched #(.PIPE_LAT(LAT), .MAX_OUT(MAXO)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .c0(c0), .a1(a1), .b1(b1), .c1(c1),
        .hold(hold), .gnt0(gnt0), .gnt1(gnt1),
        .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c),
        .pipe_ce(pipe_ce), .pipe_y(pipe_y), .res_y(res_y),
        .res_valid0(res_valid0), .res_valid1(res_valid1),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    // External (A+B)*C datapath with LAT enabled stages.
    always @(posedge clk) begin
        if (pipe_ce) begin
            for (int i = LAT - 1; i > 0; i--) dp[i] <= dp[i-1];
            dp[0] <= (17'(pipe_a) + 17'(pipe_b)) * 17'(pipe_c);
        end
    end
    assign pipe_y = dp[LAT-1];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_last   = 1'b1;
        m_state  = 0;
    endtask

    // Assert reset mid-cycle and check the immediate effects.
    task automatic pulse_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        rst  = 1'b1;
        #1;
        check("rst_gnt0", int'(gnt0), 0);
        check("rst_gnt1", int'(gnt1), 0);
        check("rst_rv", int'(res_valid0 | res_valid1), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_state", int'(state), 0);
        check("rst_pipe_a", int'(pipe_a), 0);
        check("rst_ce", int'(pipe_ce), int'(!hold));
        @(posedge clk);
        #1;
        rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input bit r0, input bit r1, input bit h,
                        input logic [7:0] x0, input logic [7:0] y0,
                        input logic [7:0] z0, input logic [7:0] x1,
                        input logic [7:0] y1, input logic [7:0] z1);
        bit s, s0, s1, e0, e1, g0, g1, bz, rq;
        int ns;
        req0 = r0; req1 = r1; hold = h;
        a0 = x0; b0 = y0; c0 = z0;
        a1 = x1; b1 = y1; c1 = z1;
        @(negedge clk);
        s  = q.size() > 0 && q[0].rem == 0 && !h;
        s0 = s && !q[0].owner;
        s1 = s && q[0].owner;
        e0 = r0 && !h && (m_cnt[0] < MAXO || s0);
        e1 = r1 && !h && (m_cnt[1] < MAXO || s1);
        g0 = e0 && (!e1 || m_last);
        g1 = e1 && (!e0 || !m_last);
        bz = q.size() > 0;
        rq = r0 | r1;
        obs_g0 = int'(gnt0); obs_g1 = int'(gnt1);
        obs_rv0 = int'(res_valid0); obs_rv1 = int'(res_valid1);
        obs_y = int'(res_y); obs_state = int'(state);
        check("gnt0", obs_g0, int'(g0));
        check("gnt1", obs_g1, int'(g1));
        check("res_valid0", obs_rv0, int'(s0));
        check("res_valid1", obs_rv1, int'(s1));
        if (s) check("res_y", obs_y, q[0].val);
        check("busy", int'(busy), int'(bz));
        check("state", obs_state, m_state);
        check("pipe_ce", int'(pipe_ce), int'(!h));
        if (h) ns = 2;
        else case (m_state)
            0:       ns = rq ? 1 : 0;
            1:       ns = (!bz && !rq && !(g0 | g1)) ? 0 : 1;
            default: ns = (bz || rq) ? 1 : 0;
        endcase
        @(posedge clk);
        if (s) void'(q.pop_front());
        if (!h) foreach (q[i]) q[i].rem--;
        if (g0) q.push_back('{1'b0, (int'(x0) + int'(y0)) * int'(z0), LAT});
        if (g1) q.push_back('{1'b1, (int'(x1) + int'(y1)) * int'(z1), LAT});
        m_cnt[0] += int'(g0) - int'(s0);
        m_cnt[1] += int'(g1) - int'(s1);
        if (g0 | g1) m_last = g1;
        m_state = ns;
        m_g0 = g0;
        m_g1 = g1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit r0, r1;
        logic [7:0] v [6];
        rst = 1'b1; hold = 1'b0; req0 = 1'b0; req1 = 1'b0;
        a0 = 0; b0 = 0; c0 = 0; a1 = 0; b1 = 0; c1 = 0;
        #2;
        pulse_reset();

        // Single operation: 3,4,5 -> 35 five cycles after the grant.
        step(1, 0, 0, 3, 4, 5, 0, 0, 0);
        check("single_gnt", obs_g0, 1);
        idle(4);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("single_rv", obs_rv0, 1);
        check("single_y", obs_y, 35);
        idle(3);

        // Contention from a fresh reset: 0,1,0,1 then credit stall.
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            step(1, 1, 0, 1, 2, 3, 4, 5, 6);
            check("cont_order", obs_g1, k % 2);
        end
        step(1, 1, 0, 1, 2, 3, 4, 5, 6);
        check("cont_stall", obs_g0 | obs_g1, 0);
        for (int k = 0; k < 4; k++) step(1, 1, 0, 1, 2, 3, 4, 5, 6);
        idle(10);

        // Outstanding limit for a lone requester.
        for (int k = 0; k < 6; k++) begin
            step(1, 0, 0, 7, 8, 9, 0, 0, 0);
            check("limit_gnt", obs_g0, (k < 2 || k == 5) ? 1 : 0);
        end
        check("limit_rv", obs_rv0, 1);
        idle(10);

        // Hold for three cycles starting two cycles after a grant.
        step(1, 0, 0, 3, 4, 5, 0, 0, 0);
        idle(1);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 1, 0, 0, 0, 1, 1, 1);
            check("hold_gnt", obs_g1, 0);
            if (k > 0) check("hold_state", obs_state, 2);
        end
        idle(3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("hold_rv", obs_rv0, 1);
        check("hold_y", obs_y, 35);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("hold_pulse", obs_rv0, 0);
        idle(4);

        // Maximum operands on requester 1.
        step(0, 1, 0, 0, 0, 0, 255, 255, 255);
        idle(4);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("max_rv1", obs_rv1, 1);
        check("max_y", obs_y, 130050);
        idle(3);

        // Reset with two operations in flight.
        step(1, 0, 0, 2, 2, 2, 0, 0, 0);
        step(1, 0, 0, 2, 2, 2, 0, 0, 0);
        idle(2);
        pulse_reset();
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0);
            check("flush_rv", obs_rv0 | obs_rv1, 0);
        end
        check("flush_state", obs_state, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 1, 1, 1, 0, 0, 0);
            check("flush_cnt", obs_g0, k < 2 ? 1 : 0);
        end
        idle(8);

        // Random traffic; operands stay put while a request is pending.
        r0 = 0; r1 = 0;
        foreach (v[i]) v[i] = 8'($urandom);
        for (int n = 0; n < 3000; n++) begin
            if (!r0 || m_g0) begin
                r0 = ($urandom_range(0, 1) == 1);
                v[0] = 8'($urandom); v[1] = 8'($urandom); v[2] = 8'($urandom);
            end
            if (!r1 || m_g1) begin
                r1 = ($urandom_range(0, 1) == 1);
                v[3] = 8'($urandom); v[4] = 8'($urandom); v[5] = 8'($urandom);
            end
            step(r0, r1, $urandom_range(0, 4) == 0,
                 v[0], v[1], v[2], v[3], v[4], v[5]);
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
